// File: rtl/traffic_light_ctrl_if.sv
// Control/status bundle for one intersection controller.
// master drives the request inputs and observes lamps; slave is the controller.
interface traffic_light_ctrl_if;
  logic       en;
  logic       night_mode;
  logic       ped_req;
  logic [1:0] light_ns;
  logic [1:0] light_ew;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_o;

  modport master (
    output en, night_mode, ped_req,
    input  light_ns, light_ew, walk, ped_pending, state_o
  );

  modport slave (
    input  en, night_mode, ped_req,
    output light_ns, light_ew, walk, ped_pending, state_o
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic light controller: Moore FSM driven by one down-counting phase timer,
// with all-red clearance, latched pedestrian walk phase and night flashing mode.
module traffic_light_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_GREEN    = 8,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_WALK     = 5,
  parameter int unsigned FLASH_HALF = 4
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StNsG   = 3'd0,
    StNsY   = 3'd1,
    StAr1   = 3'd2,
    StEwG   = 3'd3,
    StEwY   = 3'd4,
    StAr2   = 3'd5,
    StWalk  = 3'd6,
    StFlash = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] LdGreen  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LdYellow = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LdAllred = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LdWalk   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] LdFlash  = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             flash_q, flash_d;
  logic             ped_q, ped_d;
  logic             expire;
  logic             enter_walk;

  assign expire     = bus.en && (timer_q == '0);
  assign enter_walk = expire && (state_q == StAr2) && !bus.night_mode && ped_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAr2;
      timer_q <= LdAllred;
      flash_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flash_q <= flash_d;
      ped_q   <= ped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    if (bus.en && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end else if (expire) begin
      unique case (state_q)
        StNsG: begin
          state_d = StNsY;
          timer_d = LdYellow;
        end
        StNsY: begin
          state_d = StAr1;
          timer_d = LdAllred;
        end
        StAr1: begin
          state_d = bus.night_mode ? StFlash : StEwG;
          timer_d = bus.night_mode ? LdFlash : LdGreen;
        end
        StEwG: begin
          state_d = StEwY;
          timer_d = LdYellow;
        end
        StEwY: begin
          state_d = StAr2;
          timer_d = LdAllred;
        end
        StAr2: begin
          if (bus.night_mode) begin
            state_d = StFlash;
            timer_d = LdFlash;
          end else if (ped_q) begin
            state_d = StWalk;
            timer_d = LdWalk;
          end else begin
            state_d = StNsG;
            timer_d = LdGreen;
          end
        end
        StWalk: begin
          state_d = StNsG;
          timer_d = LdGreen;
        end
        StFlash: begin
          if (bus.night_mode) begin
            timer_d = LdFlash;
            flash_d = ~flash_q;
          end else begin
            state_d = StAr2;
            timer_d = LdAllred;
            flash_d = 1'b0;
          end
        end
      endcase
    end
  end

  // Clear wins over a same-cycle press: the request is being served by this WALK.
  always_comb begin
    ped_d = ped_q;
    if (enter_walk) begin
      ped_d = 1'b0;
    end else if (bus.ped_req && (state_q != StWalk)) begin
      ped_d = 1'b1;
    end
  end

  always_comb begin
    bus.light_ns = 2'b00;
    bus.light_ew = 2'b00;
    bus.walk     = 1'b0;
    unique case (state_q)
      StNsG:   bus.light_ns = 2'b01;
      StNsY:   bus.light_ns = 2'b10;
      StEwG:   bus.light_ew = 2'b01;
      StEwY:   bus.light_ew = 2'b10;
      StWalk:  bus.walk     = 1'b1;
      StFlash: begin
        bus.light_ns = flash_q ? 2'b11 : 2'b10;
        bus.light_ew = flash_q ? 2'b11 : 2'b00;
      end
      StAr1, StAr2: ;
    endcase
  end

  assign bus.ped_pending = ped_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: the stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them and also checks the red/red safety invariant.
module tb_traffic_light_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NSG = 3'd0;
  localparam logic [2:0] NSY = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] EWG = 3'd3;
  localparam logic [2:0] EWY = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;
  localparam logic [2:0] WLK = 3'd6;
  localparam logic [2:0] FLS = 3'd7;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Expected {state, ns, ew, walk, ped_pending} from the lamp table.
  function automatic logic [8:0] expv(logic [2:0] st, logic fl, logic pd);
    logic [1:0] ns;
    logic [1:0] ew;
    logic       wk;
    ns = 2'b00;
    ew = 2'b00;
    wk = 1'b0;
    case (st)
      NSG: ns = 2'b01;
      NSY: ns = 2'b10;
      EWG: ew = 2'b01;
      EWY: ew = 2'b10;
      WLK: wk = 1'b1;
      FLS: begin
        ns = fl ? 2'b11 : 2'b10;
        ew = fl ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
    return {st, ns, ew, wk, pd};
  endfunction

  // Queue n cycles of expected outputs, advancing one clock per cycle.
  task automatic obs(input string tag, input logic [2:0] st, input logic fl, input logic pd,
                     input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(expv(st, fl, pd));
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] e;
    string      tag;
    act = {bus.state_o, bus.light_ns, bus.light_ew, bus.walk, bus.ped_pending};
    if (bus.state_o != FLS) begin
      n_checks++;
      if ((bus.light_ns != 2'b00) && (bus.light_ew != 2'b00))
        $display("FAIL safety: ns=%b ew=%b both non-red in state %0d, required one red",
                 bus.light_ns, bus.light_ew, bus.state_o);
      else
        n_pass++;
    end
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s @%0t: {state,ns,ew,walk,ped} got %b required %b", tag, $time, act, e);
    end
  end

  initial begin
    bus.en         = 1'b1;
    bus.night_mode = 1'b0;
    bus.ped_req    = 1'b0;
    @(posedge clk);
    #1;
    obs("in_reset", AR2, 1'b0, 1'b0, 2);
    reset = 1'b1;

    // Plain cycle, then a second cycle that serves a pedestrian pulse seen in EW_G.
    obs("c1_ar2", AR2, 1'b0, 1'b0, 2);
    obs("c1_nsg", NSG, 1'b0, 1'b0, 8);
    obs("c1_nsy", NSY, 1'b0, 1'b0, 3);
    obs("c1_ar1", AR1, 1'b0, 1'b0, 2);
    obs("c1_ewg", EWG, 1'b0, 1'b0, 8);
    obs("c1_ewy", EWY, 1'b0, 1'b0, 3);
    obs("c1_ar2b", AR2, 1'b0, 1'b0, 2);
    obs("c2_nsg", NSG, 1'b0, 1'b0, 8);
    obs("c2_nsy", NSY, 1'b0, 1'b0, 3);
    obs("c2_ar1", AR1, 1'b0, 1'b0, 2);
    obs("c2_ewg", EWG, 1'b0, 1'b0, 3);
    bus.ped_req = 1'b1;
    obs("c2_ewg_press", EWG, 1'b0, 1'b0, 1);
    bus.ped_req = 1'b0;
    obs("c2_ewg_pend", EWG, 1'b0, 1'b1, 4);
    obs("c2_ewy_pend", EWY, 1'b0, 1'b1, 3);
    obs("c2_ar2_pend", AR2, 1'b0, 1'b1, 2);
    obs("c2_walk", WLK, 1'b0, 1'b0, 5);

    // Button held across AR_2 expiry and the whole WALK: cleared, then ignored.
    obs("c3_nsg", NSG, 1'b0, 1'b0, 8);
    obs("c3_nsy", NSY, 1'b0, 1'b0, 3);
    obs("c3_ar1", AR1, 1'b0, 1'b0, 2);
    obs("c3_ewg", EWG, 1'b0, 1'b0, 8);
    obs("c3_ewy", EWY, 1'b0, 1'b0, 3);
    bus.ped_req = 1'b1;
    obs("c3_ar2_a", AR2, 1'b0, 1'b0, 1);
    obs("c3_ar2_b", AR2, 1'b0, 1'b1, 1);
    obs("c3_walk_held", WLK, 1'b0, 1'b0, 5);
    bus.ped_req = 1'b0;
    obs("c4_nsg", NSG, 1'b0, 1'b0, 8);
    obs("c4_nsy", NSY, 1'b0, 1'b0, 3);
    obs("c4_ar1", AR1, 1'b0, 1'b0, 2);
    obs("c4_ewg", EWG, 1'b0, 1'b0, 8);
    obs("c4_ewy", EWY, 1'b0, 1'b0, 3);
    obs("c4_ar2_nowalk", AR2, 1'b0, 1'b0, 2);

    // Night mode raised in NS_G; dropped mid half-period, honoured only at expiry.
    obs("c5_nsg", NSG, 1'b0, 1'b0, 1);
    bus.night_mode = 1'b1;
    obs("c5_nsg_night", NSG, 1'b0, 1'b0, 7);
    obs("c5_nsy", NSY, 1'b0, 1'b0, 3);
    obs("c5_ar1", AR1, 1'b0, 1'b0, 2);
    obs("flash_p0", FLS, 1'b0, 1'b0, 4);
    obs("flash_p1", FLS, 1'b1, 1'b0, 4);
    obs("flash_p0b", FLS, 1'b0, 1'b0, 2);
    bus.night_mode = 1'b0;
    obs("flash_p0b_tail", FLS, 1'b0, 1'b0, 2);
    obs("flash_exit_ar2", AR2, 1'b0, 1'b0, 2);

    // Freeze mid green; a press during the freeze still latches.
    obs("c6_nsg", NSG, 1'b0, 1'b0, 3);
    bus.en = 1'b0;
    obs("freeze", NSG, 1'b0, 1'b0, 4);
    bus.ped_req = 1'b1;
    obs("freeze_press", NSG, 1'b0, 1'b0, 1);
    bus.ped_req = 1'b0;
    obs("freeze_pend", NSG, 1'b0, 1'b1, 5);
    bus.en = 1'b1;
    obs("resume_nsg", NSG, 1'b0, 1'b1, 5);
    obs("c6_nsy", NSY, 1'b0, 1'b1, 3);
    obs("c6_ar1", AR1, 1'b0, 1'b1, 2);
    obs("c6_ewg", EWG, 1'b0, 1'b1, 8);
    obs("c6_ewy", EWY, 1'b0, 1'b1, 1);

    // Asynchronous reset mid EW_Y: checked at the negedge, before any clock edge.
    reset = 1'b0;
    obs("async_reset", AR2, 1'b0, 1'b0, 2);
    reset = 1'b1;
    obs("post_reset_ar2", AR2, 1'b0, 1'b0, 2);
    obs("post_reset_nsg", NSG, 1'b0, 1'b0, 1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
